// File: rtl/nonce_sweeper.sv
// rtl/nonce_sweeper.sv - sweeps a nonce range through a single-shot double-SHA engine (optional MINER_TIMEOUT_EN)
// The engine is reset before every hash; the result is byte-reversed and compared to the target.
module nonce_sweeper #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [607:0] header_prefix,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         go,
    input  logic         abort,
    output logic         sha_rst_n,
    output logic         sha_start,
    output logic [639:0] sha_block,
    input  logic [255:0] sha_hash,
    input  logic         sha_done,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic         timeout,
    output logic [31:0]  found_nonce
);

    typedef enum logic [2:0] {
        IDLE,
        ENG_RST,
        START,
        WAIT,
        CHECK,
        DONE
    } state_t;

    state_t         r_state;
    logic [607:0]   r_header;
    logic [255:0]   r_target;
    logic [31:0]    r_nonce_end;
    logic [31:0]    r_cur_nonce;
    logic [255:0]   r_hash;
    logic           r_sha_rst_n;
    logic           r_sha_start;
    logic           r_busy;
    logic           r_found;
    logic           r_exhausted;
    logic [31:0]    r_found_nonce;
    logic [255:0]   w_hash_rev;
    logic [31:0]    w_nonce_rev;
    logic           w_meets;
    logic           w_abort;

    // Engine digest has H0 in the top word; the difficulty compare wants the whole 32 bytes reversed.
    always_comb begin
        w_hash_rev = '0;
        for (int i = 0; i < 32; i++) begin
            w_hash_rev[8*i +: 8] = r_hash[255-8*i -: 8];
        end
    end

    assign w_nonce_rev = {r_cur_nonce[7:0], r_cur_nonce[15:8], r_cur_nonce[23:16], r_cur_nonce[31:24]};
    assign w_meets     = (w_hash_rev <= r_target);
    assign w_abort     = abort && (r_state != IDLE);

    // Abort must reach the engine in the same cycle, so it bypasses the register.
    assign sha_rst_n   = r_sha_rst_n && !rst && !w_abort;
    assign sha_start   = r_sha_start;
    assign sha_block   = {r_header, w_nonce_rev};
    assign busy        = r_busy;
    assign found       = r_found;
    assign exhausted   = r_exhausted;
    assign found_nonce = r_found_nonce;

`ifdef MINER_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic        r_timeout;
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_header      <= '0;
            r_target      <= '0;
            r_nonce_end   <= '0;
            r_cur_nonce   <= '0;
            r_hash        <= '0;
            r_sha_rst_n   <= 1'b1;
            r_sha_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_found_nonce <= '0;
`ifdef MINER_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_timeout     <= 1'b0;
`endif
        end else if (w_abort && r_state != DONE) begin
            r_state     <= DONE;
            r_sha_start <= 1'b0;
            r_sha_rst_n <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_header    <= header_prefix;
                        r_target    <= target;
                        r_nonce_end <= nonce_end;
                        r_cur_nonce <= nonce_start;
                        r_found     <= 1'b0;
                        r_exhausted <= 1'b0;
`ifdef MINER_TIMEOUT_EN
                        r_timeout   <= 1'b0;
`endif
                        r_busy      <= 1'b1;
                        r_sha_rst_n <= 1'b0;
                        r_state     <= ENG_RST;
                    end
                end
                ENG_RST: begin
                    r_sha_rst_n <= 1'b1;
                    r_sha_start <= 1'b1;
                    r_state     <= START;
                end
                START: begin
                    r_sha_start <= 1'b0;
`ifdef MINER_TIMEOUT_EN
                    r_wait_cnt  <= '0;
`endif
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (sha_done) begin
                        r_hash  <= sha_hash;
                        r_state <= CHECK;
`ifdef MINER_TIMEOUT_EN
                    end else if (r_wait_cnt == 16'(TIMEOUT_CYC - 1)) begin
                        r_timeout   <= 1'b1;
                        r_sha_rst_n <= 1'b0;
                        r_state     <= DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 16'd1;
`endif
                    end
                end
                CHECK: begin
                    if (w_meets) begin
                        r_found       <= 1'b1;
                        r_found_nonce <= r_cur_nonce;
                        r_state       <= DONE;
                    end else if (r_cur_nonce == r_nonce_end) begin
                        r_exhausted <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cur_nonce <= r_cur_nonce + 32'd1;
                        r_sha_rst_n <= 1'b0;
                        r_state     <= ENG_RST;
                    end
                end
                DONE: begin
                    r_sha_rst_n <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_sweeper.sv
// tb/tb_nonce_sweeper.sv - scoreboard bench for nonce_sweeper with engine model and reference sweep
module tb_nonce_sweeper;

    localparam int MODE_MIX  = 0;
    localparam int MODE_GEN  = 1;
    localparam int MODE_HANG = 2;

    localparam logic [607:0] GEN_PREFIX = {32'h01000000, 256'h0,
        256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
        32'h29ab5f49, 32'hffff001d};
    localparam logic [255:0] GEN_REV =
        256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;
    localparam logic [31:0]  GEN_NONCE = 32'h7C2BAC1D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [607:0] header_prefix = '0;
    logic [255:0] target = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic         go = 1'b0;
    logic         abort = 1'b0;
    logic         sha_rst_n;
    logic         sha_start;
    logic [639:0] sha_block;
    logic [255:0] sha_hash = '0;
    logic         sha_done = 1'b0;
    logic         busy, found, exhausted, timeout;
    logic [31:0]  found_nonce;

    always #5 clk = ~clk;

    nonce_sweeper #(.TIMEOUT_CYC(300)) dut (
        .clk(clk), .rst(rst), .header_prefix(header_prefix), .target(target),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .go(go), .abort(abort),
        .sha_rst_n(sha_rst_n), .sha_start(sha_start), .sha_block(sha_block),
        .sha_hash(sha_hash), .sha_done(sha_done), .busy(busy), .found(found),
        .exhausted(exhausted), .timeout(timeout), .found_nonce(found_nonce)
    );

    typedef struct {
        logic        found;
        logic        exh;
        logic        tmo;
        logic [31:0] fn;
        int          starts;
        int          rstlow;
    } exp_t;

    exp_t         exp_q[$];
    logic [31:0]  nonce_q[$];
    logic [607:0] exp_prefix = '0;
    int           n_checks = 0;
    int           n_fail = 0;
    int           eng_mode = MODE_MIX;
    int           lat_fixed = 0;
    logic [31:0]  seed = 32'h1234_5678;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] bswap256(input logic [255:0] x);
        logic [255:0] y;
        for (int i = 0; i < 32; i++) y[8*i +: 8] = x[255-8*i -: 8];
        return y;
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [31:0] mix(input logic [31:0] x);
        logic [31:0] y;
        y = (x ^ seed) * 32'h9E3779B1;
        y = y ^ (y >> 16);
        y = y * 32'h85EBCA6B;
        return y ^ (y >> 13);
    endfunction

    // Numeric (already reversed) hash value the engine is going to produce for a nonce.
    function automatic logic [255:0] ref_rev(input logic [31:0] n);
        if (eng_mode == MODE_GEN) return (n == GEN_NONCE) ? GEN_REV : {256{1'b1}};
        return {mix(n), {224{1'b1}}};
    endfunction

    // Reference sweep: walk the range with modular arithmetic and record what should happen.
    task automatic model_sweep(input logic [31:0] s, input logic [31:0] e, input logic [255:0] tgt);
        exp_t        x;
        logic [31:0] n;
        x = '{found: 1'b0, exh: 1'b0, tmo: 1'b0, fn: 32'h0, starts: 0, rstlow: 0};
        n = s;
        for (int k = 0; k < 64; k++) begin
            nonce_q.push_back(n);
            x.starts++;
            if (ref_rev(n) <= tgt) begin
                x.found = 1'b1;
                x.fn    = n;
                break;
            end
            if (n == e) begin
                x.exh = 1'b1;
                break;
            end
            n = n + 32'd1;
        end
        x.rstlow = x.starts;
        exp_q.push_back(x);
    endtask

    task automatic go_pulse(input logic [607:0] p, input logic [255:0] tgt,
                            input logic [31:0] s, input logic [31:0] e, input bit garbage);
        @(negedge clk);
        header_prefix = p;
        target        = tgt;
        nonce_start   = s;
        nonce_end     = e;
        exp_prefix    = p;
        go            = 1'b1;
        @(negedge clk);
        if (garbage) begin
            header_prefix = {19{$urandom}};
            target        = '0;
            nonce_start   = $urandom;
            nonce_end     = $urandom;
            @(negedge clk);
        end
        go = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            #4;
            t++;
        end while (busy && t < 5000);
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL sweep_timeout: busy still %0b after %0d cycles, required 0", busy, t);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_start(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (!sha_start && t < 2000);
        if (!sha_start) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: sha_start not seen, got 0 required 1", name);
        end
    endtask

    // Engine model: single-shot, cleared by sha_rst_n, done is a level.
    initial begin
        bit pend;
        int cnt;
        pend = 1'b0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!sha_rst_n) begin
                sha_done = 1'b0;
                pend     = 1'b0;
            end else if (sha_start) begin
                if (eng_mode == MODE_GEN)
                    sha_hash = (sha_block == {GEN_PREFIX, bswap32(GEN_NONCE)}) ? bswap256(GEN_REV) : {256{1'b1}};
                else
                    sha_hash = bswap256(ref_rev(bswap32(sha_block[31:0])));
                pend     = (eng_mode != MODE_HANG);
                cnt      = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(0, 15));
                sha_done = 1'b0;
            end else if (pend) begin
                if (cnt == 0) begin
                    sha_done = 1'b1;
                    pend     = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Monitor: per-hash nonce/header checks and end-of-sweep status checks.
    initial begin
        logic prev_busy;
        int   cnt_st, cnt_rl;
        exp_t x;
        prev_busy = 1'b0;
        cnt_st    = 0;
        cnt_rl    = 0;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                prev_busy = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    cnt_st = 0;
                    cnt_rl = 0;
                end
                if (busy && sha_start) begin
                    cnt_st++;
                    check("hash_header", 256'(sha_block[639:32] ^ exp_prefix), 256'h0);
                    if (nonce_q.size() == 0) begin
                        check("unexpected_hash", 256'(bswap32(sha_block[31:0])), 256'h0 - 1);
                    end else begin
                        check("hash_nonce", 256'(bswap32(sha_block[31:0])), 256'(nonce_q.pop_front()));
                    end
                end
                if (busy && !sha_rst_n) cnt_rl++;
                if (!busy && prev_busy) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 256'(found), 256'h0 - 1);
                    end else begin
                        x = exp_q.pop_front();
                        check("found", 256'(found), 256'(x.found));
                        check("exhausted", 256'(exhausted), 256'(x.exh));
                        check("timeout", 256'(timeout), 256'(x.tmo));
                        if (x.found) check("found_nonce", 256'(found_nonce), 256'(x.fn));
                        check("start_pulses", 256'(cnt_st), 256'(x.starts));
                        check("rst_n_low_cycles", 256'(cnt_rl), 256'(x.rstlow));
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        exp_t        x;
        logic [31:0] s;
        int          len;

        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 256'(busy), 256'h0);
        check("rst_found", 256'(found), 256'h0);
        check("rst_exhausted", 256'(exhausted), 256'h0);
        check("rst_timeout", 256'(timeout), 256'h0);
        check("rst_sha_start", 256'(sha_start), 256'h0);
        check("rst_found_nonce", 256'(found_nonce), 256'h0);
        check("rst_sha_rst_n", 256'(sha_rst_n), 256'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("post_rst_sha_rst_n", 256'(sha_rst_n), 256'h1);

        eng_mode = MODE_MIX;
        model_sweep(32'd5, 32'd5, {256{1'b1}});
        go_pulse({19{32'hA5A5_0001}}, {256{1'b1}}, 32'd5, 32'd5, 1'b0);
        wait_idle();

        model_sweep(32'h10, 32'h13, 256'h0);
        go_pulse({19{32'h0BAD_F00D}}, 256'h0, 32'h10, 32'h13, 1'b1);
        wait_idle();

        eng_mode = MODE_GEN;
        model_sweep(32'h7C2BAC1B, 32'h7C2BAC1F, {32'h0, 16'hFFFF, 208'h0});
        go_pulse(GEN_PREFIX, {32'h0, 16'hFFFF, 208'h0}, 32'h7C2BAC1B, 32'h7C2BAC1F, 1'b0);
        wait_idle();

        eng_mode = MODE_MIX;
        model_sweep(32'hFFFFFFFE, 32'h1, 256'h0);
        go_pulse({19{32'h1111_2222}}, 256'h0, 32'hFFFFFFFE, 32'h1, 1'b0);
        wait_idle();

        for (int it = 0; it < 20; it++) begin
            seed = $urandom;
            s    = $urandom;
            len  = $urandom_range(1, 10);
            target = {$urandom & 32'h3FFF_FFFF, {224{1'b1}}};
            model_sweep(s, s + 32'(len - 1), target);
            go_pulse({19{$urandom}}, target, s, s + 32'(len - 1), 1'($urandom_range(0, 1)));
            wait_idle();
        end

        // Abort during the second hash.
        lat_fixed = 40;
        nonce_q.push_back(32'd0);
        nonce_q.push_back(32'd1);
        exp_q.push_back('{found: 1'b0, exh: 1'b0, tmo: 1'b0, fn: 32'h0, starts: 2, rstlow: 3});
        go_pulse({19{32'hCAFE_0000}}, 256'h0, 32'd0, 32'd9, 1'b0);
        wait_start("abort_first_start");
        wait_start("abort_second_start");
        repeat (5) @(negedge clk);
        abort = 1'b1;
        #1;
        check("abort_sha_rst_n", 256'(sha_rst_n), 256'h0);
        @(negedge clk);
        abort = 1'b0;
        wait_idle();

        // Reset mid-WAIT discards the sweep.
        for (int n = 100; n < 104; n++) nonce_q.push_back(32'(n));
        go_pulse({19{32'hDEAD_0000}}, 256'h0, 32'd100, 32'd103, 1'b0);
        wait_start("rst_test_start");
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_busy", 256'(busy), 256'h0);
        check("midrst_found", 256'(found), 256'h0);
        check("midrst_exhausted", 256'(exhausted), 256'h0);
        check("midrst_timeout", 256'(timeout), 256'h0);
        check("midrst_sha_start", 256'(sha_start), 256'h0);
        check("midrst_found_nonce", 256'(found_nonce), 256'h0);
        check("midrst_sha_rst_n", 256'(sha_rst_n), 256'h0);
        rst = 1'b0;
        nonce_q.delete();
        repeat (2) @(negedge clk);

        // Engine that never finishes.
        eng_mode  = MODE_HANG;
        lat_fixed = 0;
        nonce_q.push_back(32'd7);
`ifdef MINER_TIMEOUT_EN
        exp_q.push_back('{found: 1'b0, exh: 1'b0, tmo: 1'b1, fn: 32'h0, starts: 1, rstlow: 2});
        go_pulse({19{32'h7777_7777}}, 256'h0, 32'd7, 32'd7, 1'b0);
        wait_start("timeout_start");
        repeat (300) @(negedge clk);
        #1;
        check("timeout_early", 256'(timeout), 256'h0);
        @(negedge clk);
        #1;
        check("timeout_at_300", 256'(timeout), 256'h1);
`else
        exp_q.push_back('{found: 1'b0, exh: 1'b0, tmo: 1'b0, fn: 32'h0, starts: 1, rstlow: 2});
        go_pulse({19{32'h7777_7777}}, 256'h0, 32'd7, 32'd7, 1'b0);
        wait_start("hang_start");
        repeat (400) @(negedge clk);
        #1;
        check("hang_busy", 256'(busy), 256'h1);
        check("hang_timeout", 256'(timeout), 256'h0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
`endif
        wait_idle();

        check("exp_queue_drained", 256'(exp_q.size()), 256'h0);
        check("nonce_queue_drained", 256'(nonce_q.size()), 256'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
